// File: rtl/edid_i2c_slave.sv
`timescale 1ns/1ps
// edid_i2c_slave
// DDC/I2C slave front end for a 256-byte EDID ROM. It decodes host
// transactions on the raw SCL/SDA pins and supports three operations:
// offset write, current-address read and sequential read.
// It drives the address of a downstream ROM that has a 1-clk read latency.
// Bytes are shifted out MSB-first through an open-drain SDA drive.
//
// Ports:
//   clk       system clock; it must run much faster than SCL
//   rst       synchronous, active-high reset
//   scl_in    raw SCL pin level (asynchronous)
//   sda_in    raw SDA pin level (asynchronous)
//   sda_oe    1 = pull SDA low, 0 = release
//   rom_addr  byte offset presented to the EDID ROM
//   rom_data  ROM read data, valid 1 clk after rom_addr changes
//   busy      high from an address-matched START until STOP or a mismatch
module edid_i2c_slave #(
  parameter logic [6:0] DEV_ADDR   = 7'h50,
  parameter int         FILTER_LEN = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] rom_addr,
  input  logic [7:0] rom_data,
  output logic       busy
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_DEVADDR,
    S_ACK_DEV,
    S_OFFSET,
    S_ACK_OFF,   // slave ACK after the offset byte and after each discarded write byte
    S_WDATA,
    S_TX,
    S_RX_ACK,
    S_WAIT_STOP
  } state_t;

  localparam logic [2:0] CNT_MAX = 3'(FILTER_LEN - 1);

  // Input conditioning: 2-FF synchroniser, then a glitch filter.
  // The filtered level flips only after FILTER_LEN consecutive
  // samples that disagree with it.
  logic [1:0] scl_sync, sda_sync;
  logic [2:0] scl_cnt, sda_cnt;
  logic       scl_f, sda_f, scl_d, sda_d;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every
    // register samples the pre-edge value of every other register.
    if (rst) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_cnt  <= '0;
      sda_cnt  <= '0;
      scl_f    <= 1'b1;
      sda_f    <= 1'b1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl_in};
      sda_sync <= {sda_sync[0], sda_in};

      if (scl_sync[1] == scl_f) begin
        scl_cnt <= '0;
      end else if (scl_cnt == CNT_MAX) begin
        scl_f   <= scl_sync[1];
        scl_cnt <= '0;
      end else begin
        scl_cnt <= scl_cnt + 3'd1;
      end

      if (sda_sync[1] == sda_f) begin
        sda_cnt <= '0;
      end else if (sda_cnt == CNT_MAX) begin
        sda_f   <= sda_sync[1];
        sda_cnt <= '0;
      end else begin
        sda_cnt <= sda_cnt + 3'd1;
      end

      scl_d <= scl_f;
      sda_d <= sda_f;
    end
  end

  // START/STOP require SCL to be high and unchanged in this clk. If SDA and
  // SCL move in the same clk, the SDA change is treated as a data change.
  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_rise  =  scl_f & ~scl_d;
  assign scl_fall  = ~scl_f &  scl_d;
  assign start_det =  scl_f &  scl_d &  sda_d & ~sda_f;
  assign stop_det  =  scl_f &  scl_d & ~sda_d &  sda_f;

  state_t     state;
  logic [7:0] sr;        // receive shift register / transmit byte
  logic [3:0] bit_cnt;   // SCL rising edges seen in the current byte
  logic [7:0] offset;
  logic       rw;
  logic       ack_bit;   // host ACK/NACK level sampled in S_RX_ACK
  logic       byte_done;

  assign byte_done = (bit_cnt == 4'd8);
  assign rom_addr  = offset;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      sda_oe  <= 1'b0;
      busy    <= 1'b0;
      offset  <= 8'h00;
      sr      <= 8'h00;
      bit_cnt <= '0;
      rw      <= 1'b0;
      ack_bit <= 1'b1;
    end else if (stop_det) begin
      state   <= S_IDLE;
      sda_oe  <= 1'b0;
      busy    <= 1'b0;
      bit_cnt <= '0;
    end else if (start_det) begin
      // A repeated START keeps the offset, which makes a DDC random read work.
      state   <= S_DEVADDR;
      sda_oe  <= 1'b0;
      bit_cnt <= '0;
    end else if (scl_rise) begin
      case (state)
        S_DEVADDR, S_OFFSET, S_WDATA: begin
          sr      <= {sr[6:0], sda_f};
          bit_cnt <= bit_cnt + 4'd1;
        end
        S_TX:     bit_cnt <= bit_cnt + 4'd1;
        S_RX_ACK: ack_bit <= sda_f;
        default: ;
      endcase
    end else if (scl_fall) begin
      case (state)
        S_DEVADDR: begin
          if (byte_done) begin
            bit_cnt <= '0;
            if (sr[7:1] == DEV_ADDR) begin
              state  <= S_ACK_DEV;
              rw     <= sr[0];
              sda_oe <= 1'b1;
              busy   <= 1'b1;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end
        end
        S_ACK_DEV: begin
          bit_cnt <= '0;
          if (rw) begin
            // rom_addr has held the offset for many clks, so rom_data is settled.
            sr     <= rom_data;
            sda_oe <= ~rom_data[7];
            state  <= S_TX;
          end else begin
            sda_oe <= 1'b0;
            state  <= S_OFFSET;
          end
        end
        S_OFFSET: begin
          if (byte_done) begin
            bit_cnt <= '0;
            offset  <= sr;
            sda_oe  <= 1'b1;
            state   <= S_ACK_OFF;
          end
        end
        S_ACK_OFF: begin
          bit_cnt <= '0;
          sda_oe  <= 1'b0;
          state   <= S_WDATA;
        end
        S_WDATA: begin
          // The ROM is read-only: written bytes are ACKed and dropped.
          if (byte_done) begin
            bit_cnt <= '0;
            sda_oe  <= 1'b1;
            state   <= S_ACK_OFF;
          end
        end
        S_TX: begin
          if (byte_done) begin
            // Advancing the offset here gives the ROM a whole ACK bit
            // to present the next byte before it is loaded.
            bit_cnt <= '0;
            sda_oe  <= 1'b0;
            offset  <= offset + 8'd1;
            state   <= S_RX_ACK;
          end else begin
            sr     <= {sr[6:0], 1'b0};
            sda_oe <= ~sr[6];
          end
        end
        S_RX_ACK: begin
          bit_cnt <= '0;
          if (!ack_bit) begin
            sr     <= rom_data;
            sda_oe <= ~rom_data[7];
            state  <= S_TX;
          end else begin
            sda_oe <= 1'b0;
            state  <= S_WAIT_STOP;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
